// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: holds the PC and keeps one request in flight to instruction memory.
// It feeds decode with instruction/PC/PC+4, follows redirects and freezes, and inserts nop bubbles.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Alt_PC_IN,
    input  logic        Request_Alt_PC_IN,
    input  logic        FREEZE_IN,
    output logic        IMem_Req_OUT,
    output logic [31:0] IMem_Addr_OUT,
    input  logic        IMem_Ack_IN,
    input  logic        IMem_Valid_IN,
    input  logic [31:0] IMem_Data_IN,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT,
    output logic        Instr_Valid_OUT
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        squash_q, squash_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic        ivalid_q, ivalid_d;

    logic        present;
    logic [31:0] pres_data;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        squash_d  = squash_q;
        hold_d    = hold_q;
        present   = 1'b0;
        pres_data = '0;

        // Redirect outranks freeze and any response arriving on the same edge
        unique case (state_q)
            S_REQ: begin
                if (Request_Alt_PC_IN) begin
                    pc_d = Alt_PC_IN;
                    if (IMem_Ack_IN) begin
                        state_d  = S_WAIT;
                        squash_d = 1'b1;
                    end
                end else if (IMem_Ack_IN) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Request_Alt_PC_IN) begin
                    pc_d = Alt_PC_IN;
                    if (IMem_Valid_IN) begin
                        state_d  = S_REQ;
                        squash_d = 1'b0;
                    end else begin
                        squash_d = 1'b1;
                    end
                end else if (IMem_Valid_IN) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = S_REQ;
                    end else if (FREEZE_IN) begin
                        hold_d  = IMem_Data_IN;
                        state_d = S_HOLD;
                    end else begin
                        present   = 1'b1;
                        pres_data = IMem_Data_IN;
                        pc_d      = pc_q + PC_STEP;
                        state_d   = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (Request_Alt_PC_IN) begin
                    pc_d    = Alt_PC_IN;
                    hold_d  = '0;
                    state_d = S_REQ;
                end else if (!FREEZE_IN) begin
                    present   = 1'b1;
                    pres_data = hold_q;
                    pc_d      = pc_q + PC_STEP;
                    state_d   = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        instr_d  = instr_q;
        ipc_d    = ipc_q;
        ipc4_d   = ipc4_q;
        ivalid_d = ivalid_q;
        if (present) begin
            instr_d  = pres_data;
            ipc_d    = pc_q;
            ipc4_d   = pc_q + 32'd4;
            ivalid_d = 1'b1;
        end else if (!FREEZE_IN) begin
            instr_d  = '0;
            ipc_d    = '0;
            ipc4_d   = '0;
            ivalid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            squash_q <= 1'b0;
            hold_q   <= '0;
            instr_q  <= '0;
            ipc_q    <= '0;
            ipc4_q   <= '0;
            ivalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
            hold_q   <= hold_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            ipc4_q   <= ipc4_d;
            ivalid_q <= ivalid_d;
        end
    end

    // Request is gated by the reset pin itself so it drops the instant reset asserts
    assign IMem_Req_OUT       = RESET && (state_q == S_REQ);
    assign IMem_Addr_OUT      = pc_q;
    assign Instr1_OUT         = instr_q;
    assign Instr_PC_OUT       = ipc_q;
    assign Instr_PC_Plus4_OUT = ipc4_q;
    assign Instr_Valid_OUT    = ivalid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a gated memory model plus a scoreboard of expected presented PCs,
// checked against the outputs after every rising edge.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Alt_PC_IN;
    logic        Request_Alt_PC_IN;
    logic        FREEZE_IN;
    logic        IMem_Req_OUT;
    logic [31:0] IMem_Addr_OUT;
    logic        IMem_Ack_IN;
    logic        IMem_Valid_IN;
    logic [31:0] IMem_Data_IN;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4_OUT;
    logic        Instr_Valid_OUT;

    instr_fetch_unit #(
        .RESET_PC(32'h0040_0000),
        .PC_STEP (32'd4)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .Alt_PC_IN         (Alt_PC_IN),
        .Request_Alt_PC_IN (Request_Alt_PC_IN),
        .FREEZE_IN         (FREEZE_IN),
        .IMem_Req_OUT      (IMem_Req_OUT),
        .IMem_Addr_OUT     (IMem_Addr_OUT),
        .IMem_Ack_IN       (IMem_Ack_IN),
        .IMem_Valid_IN     (IMem_Valid_IN),
        .IMem_Data_IN      (IMem_Data_IN),
        .Instr1_OUT        (Instr1_OUT),
        .Instr_PC_OUT      (Instr_PC_OUT),
        .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT),
        .Instr_Valid_OUT   (Instr_Valid_OUT)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    int          mem_lat = 2;
    bit          ack_allow = 1'b0;
    bit          ack_seen = 1'b0;
    bit          mem_off = 1'b1;
    bit          stale_inj = 1'b0;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] ack_addr = '0;
    logic [31:0] pend_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: acks only when the bench allows one fetch, answers mem_lat cycles later
    initial begin
        IMem_Ack_IN   = 1'b0;
        IMem_Valid_IN = 1'b0;
        IMem_Data_IN  = '0;
        forever begin
            @(negedge CLK);
            IMem_Ack_IN   = 1'b0;
            IMem_Valid_IN = 1'b0;
            if (mem_off) begin
                pend          = 1'b0;
                IMem_Valid_IN = stale_inj;
                IMem_Data_IN  = 32'hBAD0_BAD0;
            end else if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    IMem_Valid_IN = 1'b1;
                    IMem_Data_IN  = mem_word(pend_addr);
                    pend          = 1'b0;
                end
            end else if (ack_allow && IMem_Req_OUT) begin
                IMem_Ack_IN = 1'b1;
                ack_addr    = IMem_Addr_OUT;
                pend_addr   = IMem_Addr_OUT;
                ack_seen    = 1'b1;
                ack_allow   = 1'b0;
                pend        = 1'b1;
                cnt         = mem_lat;
            end
        end
    end

    // Output monitor: frozen edges must hold, otherwise a presentation pops the scoreboard or a bubble is all zeros
    logic [31:0] p_instr = '0, p_pc = '0, p_pc4 = '0;
    logic        p_val = 1'b0;
    bit          frz;
    logic [31:0] e;
    initial begin
        forever begin
            @(posedge CLK);
            frz = FREEZE_IN;
            #1;
            if (RESET === 1'b1) begin
                if (frz) begin
                    check_eq("hold_instr", Instr1_OUT, p_instr);
                    check_eq("hold_pc", Instr_PC_OUT, p_pc);
                    check_eq("hold_pc4", Instr_PC_Plus4_OUT, p_pc4);
                    check_eq("hold_valid", 32'(Instr_Valid_OUT), 32'(p_val));
                end else if (Instr_Valid_OUT) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_present", 32'(Instr_Valid_OUT), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("pres_pc", Instr_PC_OUT, e);
                        check_eq("pres_pc4", Instr_PC_Plus4_OUT, e + 32'd4);
                        check_eq("pres_instr", Instr1_OUT, mem_word(e));
                    end
                end else begin
                    check_eq("bubble_instr", Instr1_OUT, 32'd0);
                    check_eq("bubble_pc", Instr_PC_OUT, 32'd0);
                    check_eq("bubble_pc4", Instr_PC_Plus4_OUT, 32'd0);
                end
            end
            p_instr = Instr1_OUT;
            p_pc    = Instr_PC_OUT;
            p_pc4   = Instr_PC_Plus4_OUT;
            p_val   = Instr_Valid_OUT;
        end
    end

    task automatic fetch_one(input logic [31:0] addr, input bit present);
        ack_seen  = 1'b0;
        ack_allow = 1'b1;
        for (int i = 0; i < 40 && !ack_seen; i++) begin
            @(negedge CLK);
            #1;
        end
        ack_allow = 1'b0;
        check_eq("ack_seen", 32'(ack_seen), 32'd1);
        if (ack_seen) begin
            check_eq("fetch_addr", ack_addr, addr);
            if (present) exp_q.push_back(addr);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(negedge CLK);
            #1;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_instr"}, Instr1_OUT, 32'd0);
        check_eq({tag, "_pc"}, Instr_PC_OUT, 32'd0);
        check_eq({tag, "_pc4"}, Instr_PC_Plus4_OUT, 32'd0);
        check_eq({tag, "_valid"}, 32'(Instr_Valid_OUT), 32'd0);
        check_eq({tag, "_req"}, 32'(IMem_Req_OUT), 32'd0);
    endtask

    initial begin
        RESET             = 1'b0;
        Alt_PC_IN         = '0;
        Request_Alt_PC_IN = 1'b0;
        FREEZE_IN         = 1'b0;

        repeat (3) @(negedge CLK);
        #1;
        check_zero_outputs("reset");
        mem_lat = 2;
        mem_off = 1'b0;
        RESET   = 1'b1;

        // sequential fetches from the reset PC
        fetch_one(32'h0040_0000, 1'b1);
        fetch_one(32'h0040_0004, 1'b1);
        drain();

        // redirect while waiting on 0x00400008: its data is squashed
        fetch_one(32'h0040_0008, 1'b0);
        @(negedge CLK);
        Request_Alt_PC_IN = 1'b1;
        Alt_PC_IN         = 32'h0040_0100;
        @(negedge CLK);
        Request_Alt_PC_IN = 1'b0;
        #1;
        check_eq("redir_bubble", 32'(Instr_Valid_OUT), 32'd0);
        fetch_one(32'h0040_0100, 1'b1);
        fetch_one(32'h0040_0104, 1'b1);
        drain();

        // freeze while the response lands: parked in the hold buffer, shown after release
        FREEZE_IN = 1'b1;
        fetch_one(32'h0040_0108, 1'b1);
        repeat (4) @(negedge CLK);
        FREEZE_IN = 1'b0;
        @(negedge CLK);
        #1;
        check_eq("unfreeze_pc", Instr_PC_OUT, 32'h0040_0108);
        drain();

        // redirect while holding a buffered instruction: buffer is dropped
        FREEZE_IN = 1'b1;
        fetch_one(32'h0040_010C, 1'b0);
        repeat (3) @(negedge CLK);
        Request_Alt_PC_IN = 1'b1;
        Alt_PC_IN         = 32'h0040_0200;
        @(negedge CLK);
        Request_Alt_PC_IN = 1'b0;
        @(negedge CLK);
        FREEZE_IN = 1'b0;
        @(negedge CLK);
        #1;
        check_eq("hold_redir_bubble", 32'(Instr_Valid_OUT), 32'd0);
        fetch_one(32'h0040_0200, 1'b1);
        drain();

        // redirect on the same edge as the ack of 0x00400204
        ack_seen  = 1'b0;
        ack_allow = 1'b1;
        @(negedge CLK);
        Request_Alt_PC_IN = 1'b1;
        Alt_PC_IN         = 32'h0040_0300;
        #1;
        check_eq("coinc_ack", 32'(ack_seen), 32'd1);
        check_eq("coinc_addr", ack_addr, 32'h0040_0204);
        ack_allow = 1'b0;
        @(negedge CLK);
        Request_Alt_PC_IN = 1'b0;
        fetch_one(32'h0040_0300, 1'b1);
        drain();

        // unaligned redirect near the top of the address space: PC+4 wraps
        @(negedge CLK);
        Request_Alt_PC_IN = 1'b1;
        Alt_PC_IN         = 32'hFFFF_FFFE;
        @(negedge CLK);
        Request_Alt_PC_IN = 1'b0;
        #1;
        check_eq("redir_addr", IMem_Addr_OUT, 32'hFFFF_FFFE);
        check_eq("redir_req", 32'(IMem_Req_OUT), 32'd1);
        fetch_one(32'hFFFF_FFFE, 1'b1);
        fetch_one(32'h0000_0002, 1'b1);
        drain();

        // async reset in the middle of an outstanding fetch, with stale Valid during reset
        mem_lat = 4;
        fetch_one(32'h0000_0006, 1'b0);
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        mem_off   = 1'b1;
        stale_inj = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        check_zero_outputs("stale_rst");
        stale_inj = 1'b0;
        @(negedge CLK);
        #1;
        exp_q.delete();
        mem_off = 1'b0;
        RESET   = 1'b1;
        fetch_one(32'h0040_0000, 1'b1);
        drain();

        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
